seq_shifter: RTL and testbench



---
 rtl/shifter_pkg.sv | 17 +
 rtl/shift_step.sv | 25 ++
 rtl/seq_shifter.sv | 87 ++++++++
 tb/tb_seq_shifter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared types for the sequential shifter: operation encoding and FSM states.
package shifter_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_RSV = 2'b10,
    OP_SRA = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One combinational shift step of distance d; the reserved op passes data through.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  op_e              op,
  input  logic [SHW-1:0]   d,
  output logic [WIDTH-1:0] result
);

  // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
  always_comb begin
    result = data;
    case (op)
      OP_SLL:  result = data << d;
      OP_SRL:  result = data >> d;
      OP_SRA:  result = WIDTH'($signed(data) >>> d);
      default: result = data;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: moves at most STEP bit positions per clock, with a
// valid/ready request side and a valid/ready result side.
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  // Remaining distance never exceeds WIDTH-1, so a STEP of WIDTH clamps to that.
  localparam logic [SHW-1:0] STEP_CAP = (STEP >= WIDTH) ? SHW'(WIDTH - 1) : SHW'(STEP);

  state_e           state, state_nx;
  logic [WIDTH-1:0] data_q, res_q, step_out;
  logic [SHW-1:0]   rem_q, d;
  op_e              op_q;
  logic             accept, last_step;

  assign accept    = (state == IDLE) && in_valid;
  assign d         = (rem_q < STEP_CAP) ? rem_q : STEP_CAP;
  assign last_step = (rem_q == d);

  shift_step #(.WIDTH(WIDTH)) u_step (
    .data   (data_q),
    .op     (op_q),
    .d      (d),
    .result (step_out)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = (in_shamt == '0) ? DONE : SHIFT;
      SHIFT:   if (last_step) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // res_q is loaded only on entry to DONE, so out_data holds while shifting and idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      res_q  <= '0;
      rem_q  <= '0;
      op_q   <= OP_SLL;
    end else if (flush) begin
      rem_q <= '0;
    end else if (accept) begin
      data_q <= in_data;
      op_q   <= op_e'(in_op);
      rem_q  <= in_shamt;
      if (in_shamt == '0) res_q <= in_data;
    end else if (state == SHIFT) begin
      data_q <= step_out;
      rem_q  <= rem_q - d;
      if (last_step) res_q <= step_out;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = res_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: a STEP=1 and a STEP=4 instance share all inputs and
// are compared against a bit-level reference model and a latency formula.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [4:0]  in_shamt = '0;
  logic [1:0]  in_op = '0;
  logic        out_ready = 1'b1;

  logic        in_ready1, out_valid1, busy1;
  logic        in_ready4, out_valid4, busy4;
  logic [31:0] out_data1, out_data4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(32), .STEP(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .in_shamt(in_shamt), .in_op(in_op),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .busy(busy1)
  );

  seq_shifter #(.WIDTH(32), .STEP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .in_shamt(in_shamt), .in_op(in_op),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .busy(busy4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: each result bit is picked from its source position in the operand.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [1:0] op, input int sh);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      case (op)
        2'b00:   r[i] = (i >= sh) ? a[i - sh] : 1'b0;
        2'b01:   r[i] = (i + sh < 32) ? a[i + sh] : 1'b0;
        2'b11:   r[i] = (i + sh < 32) ? a[i + sh] : a[31];
        default: r[i] = a[i];
      endcase
    end
    return r;
  endfunction

  function automatic int exp_lat(input int sh, input int step);
    return (sh == 0) ? 1 : 1 + (sh + step - 1) / step;
  endfunction

  // Issue one request and follow both instances through to their handshakes.
  task automatic run_op(input logic [31:0] a, input int sh, input logic [1:0] op,
                        input logic [31:0] exp, input string name);
    int lat1 = 0;
    int lat4 = 0;
    logic [31:0] r1 = '0;
    logic [31:0] r4 = '0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = a;
    in_shamt = 5'(sh);
    in_op    = op;
    for (int e = 1; e <= 100 && (lat1 == 0 || lat4 == 0); e++) begin
      @(posedge clk); #1;
      if (e == 1) begin
        in_valid = 1'b0;
        in_data  = ~a;
        in_op    = ~op;
      end
      if (lat1 == 0 && out_valid1) begin
        lat1 = e; r1 = out_data1;
        check({name, " ready_in_done1"}, 32'(in_ready1), 32'd0);
      end
      if (lat4 == 0 && out_valid4) begin
        lat4 = e; r4 = out_data4;
        check({name, " ready_in_done4"}, 32'(in_ready4), 32'd0);
      end
    end
    check({name, " data1"}, r1, exp);
    check({name, " data4"}, r4, exp);
    check({name, " lat1"}, 32'(lat1), 32'(exp_lat(sh, 1)));
    check({name, " lat4"}, 32'(lat4), 32'(exp_lat(sh, 4)));
    @(posedge clk); #1;
    check({name, " idle_after"}, {30'd0, in_ready1, in_ready4}, 32'd3);
  endtask

  typedef struct {
    string       name;
    logic [31:0] data;
    int          sh;
    logic [1:0]  op;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{"sll_1_by_31",  32'h0000_0001, 31, 2'b00, 32'h8000_0000};
    vecs[1] = '{"sra_msb_by_31", 32'h8000_0000, 31, 2'b11, 32'hFFFF_FFFF};
    vecs[2] = '{"srl_msb_by_31", 32'h8000_0000, 31, 2'b01, 32'h0000_0001};
    vecs[3] = '{"srl_by_0",     32'hDEAD_BEEF,  0, 2'b01, 32'hDEAD_BEEF};
    vecs[4] = '{"rsv_by_5",     32'h1234_5678,  5, 2'b10, 32'h1234_5678};
    vecs[5] = '{"sra_pos_by_4", 32'h7FFF_0000,  4, 2'b11, 32'h07FF_F000};
    vecs[6] = '{"sll_3_by_2",   32'h0000_0003,  2, 2'b00, 32'h0000_000C};
    vecs[7] = '{"srl_by_7",     32'hF000_0080,  7, 2'b01, 32'h01E0_0001};

    #12;
    check("reset in_ready", {30'd0, in_ready1, in_ready4}, 32'd3);
    check("reset out_valid", {30'd0, out_valid1, out_valid4}, 32'd0);
    check("reset busy", {30'd0, busy1, busy4}, 32'd0);
    check("reset out_data", out_data1 | out_data4, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) run_op(vecs[i].data, vecs[i].sh, vecs[i].op, vecs[i].exp, vecs[i].name);

    for (int i = 0; i < 30; i++) begin
      logic [31:0] a;
      int sh;
      logic [1:0] op;
      a  = $urandom;
      sh = $urandom_range(0, 31);
      op = 2'($urandom_range(0, 3));
      run_op(a, sh, op, model(a, op, sh), $sformatf("rand%0d", i));
    end

    // Back-pressure: result held, in_valid ignored in DONE and on the handshake edge.
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h0000_00A5; in_shamt = 5'd3; in_op = 2'b00;
    @(posedge clk); #1;
    in_data = 32'h5555_5555; in_shamt = 5'd1; in_op = 2'b01;
    for (int e = 0; e < 20 && !(out_valid1 && out_valid4); e++) begin
      @(posedge clk); #1;
    end
    for (int c = 0; c < 5; c++) begin
      check("bp out_valid", {30'd0, out_valid1, out_valid4}, 32'd3);
      check("bp data1", out_data1, 32'h0000_0528);
      check("bp data4", out_data4, 32'h0000_0528);
      check("bp in_ready", {30'd0, in_ready1, in_ready4}, 32'd0);
      check("bp busy", {30'd0, busy1, busy4}, 32'd3);
      @(posedge clk); #1;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp handshake out_valid", {30'd0, out_valid1, out_valid4}, 32'd0);
    check("bp handshake in_ready", {30'd0, in_ready1, in_ready4}, 32'd3);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Flush in mid-SHIFT.
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h0000_0001; in_shamt = 5'd20; in_op = 2'b00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("pre-flush busy", {30'd0, busy1, busy4}, 32'd3);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush in_ready", {30'd0, in_ready1, in_ready4}, 32'd3);
    check("flush busy", {30'd0, busy1, busy4}, 32'd0);
    for (int c = 0; c < 10; c++) begin
      check("flush no out_valid", {30'd0, out_valid1, out_valid4}, 32'd0);
      @(posedge clk); #1;
    end
    run_op(32'h3, 2, 2'b00, 32'h0000_000C, "post_flush");

    // Reset pulse in mid-SHIFT.
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'hFFFF_0000; in_shamt = 5'd24; in_op = 2'b01;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst async busy", {30'd0, busy1, busy4}, 32'd0);
    check("rst async out_valid", {30'd0, out_valid1, out_valid4}, 32'd0);
    check("rst async out_data", out_data1 | out_data4, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-rst in_ready", {30'd0, in_ready1, in_ready4}, 32'd3);
    for (int c = 0; c < 10; c++) begin
      check("post-rst no out_valid", {30'd0, out_valid1, out_valid4}, 32'd0);
      @(posedge clk); #1;
    end
    run_op(32'h3, 2, 2'b00, 32'h0000_000C, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
